xm_stage_reg: RTL and testbench

Parametrised execute/memory pipeline stage register carrying PC, instruction, ALU result, B operand and overflow flag from X to M. Adds a valid/ready handshake with a two-entry skid buffer, so backpressure from M never combinationally reaches X. Adds a flush that squashes in-flight entries to NOP bubbles and a saturating stall counter for performance debug. Sits between the ALU/branch unit and the data-memory stage of the 5-stage core.

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/dffe_ref.sv | 20 ++
 rtl/skid_buf.sv | 101 ++++++++++
 rtl/xm_stage_reg.sv | 63 ++++++
 tb/tb_xm_stage_reg.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: skid-buffer state
// encoding, X/M payload layout and the default bubble instruction.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  localparam int          XM_DATA_W    = 32;
  localparam logic [31:0] NOP_INS_DEF  = 32'h0000_0000;

  // Field order matches the bit packing used by xm_stage_reg (pc is the MSB).
  typedef struct packed {
    logic [XM_DATA_W-1:0] pc;
    logic [XM_DATA_W-1:0] ins;
    logic [XM_DATA_W-1:0] o;
    logic [XM_DATA_W-1:0] b;
    logic                 ovf;
  } xm_payload_t;

  localparam int XM_PAYLOAD_W = $bits(xm_payload_t);

  function automatic int xm_payload_w(input int data_w);
    return 4 * data_w + 1;
  endfunction

endpackage

// File: rtl/dffe_ref.sv
// Reference enable flop with asynchronous active-high clear to a
// parameterised value; every state element in this slice is built from it.
module dffe_ref #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses <= so all flops sample pre-edge values together.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)     q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/skid_buf.sv
// Two-entry valid/ready skid buffer with registered in_ready and flush.
// Fields selected by SCRUB_MASK are forced to SCRUB_VAL whenever a slot empties.
module skid_buf
  import pipe_pkg::*;
#(
  parameter int           W          = 8,
  parameter logic [W-1:0] SCRUB_MASK = '0,
  parameter logic [W-1:0] SCRUB_VAL  = '0
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  localparam logic [W-1:0] EMPTY_VAL = SCRUB_VAL & SCRUB_MASK;

  function automatic logic [W-1:0] scrub(input logic [W-1:0] d);
    return (d & ~SCRUB_MASK) | EMPTY_VAL;
  endfunction

  logic        clr;
  logic [1:0]  state_q;
  skid_state_e state, state_d;
  logic        acc, pop;
  logic        main_en, skid_en;
  logic [W-1:0] main_q, main_d, skid_q, skid_d;

  assign clr   = ~clr_n;
  assign state = skid_state_e'(state_q);
  assign acc   = in_valid & in_ready;
  assign pop   = out_valid & out_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state;
    main_en = 1'b0;
    main_d  = in_data;
    skid_en = 1'b0;
    skid_d  = in_data;
    unique case (state)
      ST_EMPTY: if (acc) begin
        main_en = 1'b1;
        state_d = ST_ONE;
      end
      ST_ONE: begin
        if (acc && pop) begin
          main_en = 1'b1;
        end else if (acc) begin
          skid_en = 1'b1;
          state_d = ST_FULL;
        end else if (pop) begin
          main_en = 1'b1;
          main_d  = scrub(main_q);
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: if (pop) begin
        main_en = 1'b1;
        main_d  = skid_q;
        state_d = ST_ONE;
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush wins over any accept; a same-cycle pop has already been consumed by M.
    if (flush) begin
      state_d = ST_EMPTY;
      main_en = 1'b1;
      main_d  = scrub(main_q);
      skid_en = 1'b1;
      skid_d  = scrub(skid_q);
    end
  end

  dffe_ref #(.W(2), .RST_VAL(ST_EMPTY)) u_state (
    .clk(clk), .clr(clr), .en(1'b1), .d(state_d), .q(state_q)
  );

  // in_ready is its own flop so out_ready never reaches X combinationally.
  dffe_ref #(.W(1), .RST_VAL(1'b1)) u_ready (
    .clk(clk), .clr(clr), .en(1'b1), .d(state_d != ST_FULL), .q(in_ready)
  );

  // NOTE: payload slots are reset too, so outputs show defined bubbles after reset.
  dffe_ref #(.W(W), .RST_VAL(EMPTY_VAL)) u_main (
    .clk(clk), .clr(clr), .en(main_en), .d(main_d), .q(main_q)
  );

  dffe_ref #(.W(W), .RST_VAL(EMPTY_VAL)) u_skid (
    .clk(clk), .clr(clr), .en(skid_en), .d(skid_d), .q(skid_q)
  );

  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_q;

endmodule

// File: rtl/xm_stage_reg.sv
// X->M pipeline stage register: packs pc/ins/o/b/ovf into a skid buffer and
// counts cycles M holds back a valid entry (saturating, reset-only clear).
module xm_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 DATA_W  = XM_DATA_W,
  parameter logic [DATA_W-1:0]  NOP_INS = DATA_W'(NOP_INS_DEF),
  parameter int                 CNT_W   = 16
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_ins,
  input  logic [DATA_W-1:0] in_o,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_ovf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_ins,
  output logic [DATA_W-1:0] out_o,
  output logic [DATA_W-1:0] out_b,
  output logic              out_ovf,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int PW = xm_payload_w(DATA_W);
  localparam logic [DATA_W-1:0] ZW = '0;
  // Empty slots show NOP_INS with ovf cleared; pc/o/b keep their last value.
  localparam logic [PW-1:0] SCRUB_MASK = {ZW, {DATA_W{1'b1}}, ZW, ZW, 1'b1};
  localparam logic [PW-1:0] SCRUB_VAL  = {ZW, NOP_INS, ZW, ZW, 1'b0};

  logic [PW-1:0] in_data, out_data;
  logic          cnt_en;

  assign in_data = {in_pc, in_ins, in_o, in_b, in_ovf};
  assign {out_pc, out_ins, out_o, out_b, out_ovf} = out_data;

  skid_buf #(
    .W(PW), .SCRUB_MASK(SCRUB_MASK), .SCRUB_VAL(SCRUB_VAL)
  ) u_skid_buf (
    .clk      (clk),
    .clr_n    (clr_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  assign cnt_en = out_valid & ~out_ready & (stall_cnt != {CNT_W{1'b1}});

  dffe_ref #(.W(CNT_W), .RST_VAL('0)) u_stall_cnt (
    .clk(clk), .clr(~clr_n), .en(cnt_en),
    .d(stall_cnt + CNT_W'(1)), .q(stall_cnt)
  );

endmodule

// File: tb/tb_xm_stage_reg.sv
// Directed bench for xm_stage_reg: reset, streaming, backpressure, flush,
// async reset while full, and stall counter saturation (CNT_W=4).
module tb_xm_stage_reg;

  localparam int          DW  = 32;
  localparam int          CW  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          clr_n;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_pc, in_ins, in_o, in_b;
  logic          in_ovf;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_pc, out_ins, out_o, out_b;
  logic          out_ovf;
  logic          flush;
  logic [CW-1:0] stall_cnt;

  int vectors = 0;
  int errors  = 0;

  xm_stage_reg #(.DATA_W(DW), .NOP_INS(NOP), .CNT_W(CW)) dut (
    .clk(clk), .clr_n(clr_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_ins(in_ins), .in_o(in_o), .in_b(in_b), .in_ovf(in_ovf),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_ins(out_ins), .out_o(out_o), .out_b(out_b), .out_ovf(out_ovf),
    .flush(flush), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Payload derived from pc so each entry is distinguishable on every field.
  task automatic drive(input logic v, input logic [DW-1:0] pc, input logic ovf);
    in_valid = v;
    in_pc    = pc;
    in_ins   = 32'hA000_0000 | pc;
    in_o     = 32'h0B00_0000 | pc;
    in_b     = 32'h00C0_0000 | pc;
    in_ovf   = ovf;
  endtask

  initial begin
    clr_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 32'h10, 1'b1);

    // Reset held with in_valid=1: nothing captured.
    #22;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_ins",   out_ins,   NOP);
    check("rst_out_pc",    out_pc,    0);
    check("rst_out_ovf",   out_ovf,   0);
    check("rst_stall",     stall_cnt, 0);

    @(negedge clk) clr_n = 1'b1;
    tick();
    check("first_valid", out_valid, 1);
    check("first_pc",    out_pc,    32'h10);
    check("first_ins",   out_ins,   32'hA000_0010);
    check("first_o",     out_o,     32'h0B00_0010);
    check("first_b",     out_b,     32'h00C0_0010);
    check("first_ovf",   out_ovf,   1);
    drive(1'b0, 32'h0, 1'b0);
    out_ready = 1'b1;
    tick();
    check("first_drain_valid", out_valid, 0);
    check("first_drain_ins",   out_ins,   NOP);
    check("first_drain_ovf",   out_ovf,   0);

    // Streaming at one entry per cycle.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, DW'(i), i[0]);
      tick();
      check("stream_pc",    out_pc,    i);
      check("stream_valid", out_valid, 1);
      check("stream_ready", in_ready,  1);
    end
    drive(1'b0, 32'h0, 1'b0);
    tick();
    check("stream_end_valid", out_valid, 0);
    check("stream_stall",     stall_cnt, 0);

    // Backpressure: second entry goes to skid, in_ready drops, then drain.
    out_ready = 1'b0;
    drive(1'b1, 32'h20, 1'b0);
    tick();
    check("bp1_pc",    out_pc,    32'h20);
    check("bp1_ready", in_ready,  1);
    check("bp1_stall", stall_cnt, 0);
    drive(1'b1, 32'h21, 1'b1);
    tick();
    check("bp2_pc",    out_pc,    32'h20);
    check("bp2_ready", in_ready,  0);
    check("bp2_stall", stall_cnt, 1);
    drive(1'b1, 32'h22, 1'b0);
    tick();
    check("bp3_pc",    out_pc,    32'h20);
    check("bp3_ready", in_ready,  0);
    check("bp3_stall", stall_cnt, 2);
    out_ready = 1'b1;
    tick();
    check("bp4_pc",    out_pc,    32'h21);
    check("bp4_ovf",   out_ovf,   1);
    check("bp4_ready", in_ready,  1);
    check("bp4_stall", stall_cnt, 2);
    tick();
    check("bp5_pc",    out_pc,    32'h22);
    check("bp5_valid", out_valid, 1);
    drive(1'b0, 32'h0, 1'b0);
    tick();
    check("bp6_valid", out_valid, 0);
    check("bp6_pc",    out_pc,    32'h22);
    check("bp6_ins",   out_ins,   NOP);

    // Flush from FULL with a competing input.
    out_ready = 1'b0;
    drive(1'b1, 32'h30, 1'b1);
    tick();
    drive(1'b1, 32'h31, 1'b1);
    tick();
    check("fl_pre_ready", in_ready,  0);
    check("fl_pre_stall", stall_cnt, 3);
    flush = 1'b1;
    drive(1'b1, 32'h32, 1'b1);
    tick();
    check("fl_valid", out_valid, 0);
    check("fl_ins",   out_ins,   NOP);
    check("fl_ovf",   out_ovf,   0);
    check("fl_ready", in_ready,  1);
    check("fl_stall", stall_cnt, 4);
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    tick();
    check("fl_after_valid", out_valid, 0);
    out_ready = 1'b1;
    drive(1'b1, 32'h40, 1'b0);
    tick();
    check("fl_next_pc",    out_pc,    32'h40);
    check("fl_next_valid", out_valid, 1);
    drive(1'b0, 32'h0, 1'b0);
    tick();
    check("fl_next_drain", out_valid, 0);

    // Asynchronous reset between edges while FULL.
    out_ready = 1'b0;
    drive(1'b1, 32'h50, 1'b1);
    tick();
    drive(1'b1, 32'h51, 1'b1);
    tick();
    check("ar_pre_ready", in_ready, 0);
    #2 clr_n = 1'b0;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_ready", in_ready,  1);
    check("ar_pc",    out_pc,    0);
    check("ar_ins",   out_ins,   NOP);
    check("ar_ovf",   out_ovf,   0);
    check("ar_stall", stall_cnt, 0);
    drive(1'b0, 32'h0, 1'b0);
    @(negedge clk) clr_n = 1'b1;

    // Stall counter saturation at 2^4-1.
    drive(1'b1, 32'h60, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    check("sat_start", stall_cnt, 0);
    for (int i = 0; i < 14; i++) tick();
    check("sat_14", stall_cnt, 14);
    tick();
    check("sat_15", stall_cnt, 15);
    for (int i = 0; i < 5; i++) tick();
    check("sat_hold", stall_cnt, 15);
    check("sat_pc",   out_pc,    32'h60);
    out_ready = 1'b1;
    tick();
    check("sat_drain", out_valid, 0);
    check("sat_keep",  stall_cnt, 15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
